// File: rtl/sic_mem_arb_pkg.sv
// Shared types, widths and the age helper for the SIC data-memory arbiter.
// Contents: default sizing localparams, sic_idx_t, age_of().
package sic_mem_arb_pkg;

   localparam int unsigned NUM_SIC_DEF  = 4;
   localparam int unsigned ID_WIDTH_DEF = 6;
   localparam int unsigned ID_W_MAX     = 16;
   localparam int unsigned ADDR_W       = 30;
   localparam int unsigned DATA_W       = 32;

   typedef logic [$clog2(NUM_SIC_DEF)-1:0] sic_idx_t;

   // Distance of id from the issue head, modulo 2**width; smaller is older.
   function automatic logic [ID_W_MAX-1:0] age_of(input logic [ID_W_MAX-1:0] id,
                                                  input logic [ID_W_MAX-1:0] head,
                                                  input int unsigned         width);
      logic [ID_W_MAX-1:0] mask;
      mask = ID_W_MAX'((32'd1 << width) - 32'd1);
      return (id - head) & mask;
   endfunction

endpackage

// File: rtl/sic_mem_age_select.sv
// Combinational min-age select over the eligible SICs.
// Ports: elig_i (eligible vector), age_i (packed ages, SIC0 in LSBs),
//        vld_c_o (any eligible), idx_c_o (oldest eligible; ties -> lowest index).
module sic_mem_age_select #(
   parameter int unsigned NUM_SIC  = 4,
   parameter int unsigned ID_WIDTH = 6,
   localparam int unsigned IDX_W   = $clog2(NUM_SIC)
) (
   input  logic [NUM_SIC-1:0]          elig_i,
   input  logic [NUM_SIC*ID_WIDTH-1:0] age_i,
   output logic                        vld_c_o,
   output logic [IDX_W-1:0]            idx_c_o
);

   logic                found;
   logic [IDX_W-1:0]    idx;
   logic [ID_WIDTH-1:0] best;

   // Strict less-than keeps the lower index on equal ages.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      best  = '0;
      for (int unsigned i = 0; i < NUM_SIC; i++) begin
         if (elig_i[i] && (!found || (age_i[i*ID_WIDTH +: ID_WIDTH] < best))) begin
            found = 1'b1;
            idx   = IDX_W'(i);
            best  = age_i[i*ID_WIDTH +: ID_WIDTH];
         end
      end
      vld_c_o = found;
      idx_c_o = idx;
   end

endmodule

// File: rtl/sic_mem_arbiter.sv
// Data-memory lock arbiter: grants the oldest requesting SIC (relative to the
// issue head) for one cycle and muxes its addr/wdata/wen onto the single-port
// data memory. Read data is broadcast to all SICs.
// Ports: clk, rst (sync, active high), head_issue_id, req, req_issue_id,
//        release_lock, sic_addr, sic_wdata, sic_wen -> mem_grant (registered
//        one-hot), mem_rdata, dmem_addr, dmem_wdata, dmem_wen; dmem_rdata in.
// Optional: define SIC_MEM_ARB_STATS_EN to add stat_grants / stat_conflicts.
module sic_mem_arbiter
   import sic_mem_arb_pkg::*;
#(
   parameter int unsigned NUM_SIC  = NUM_SIC_DEF,
   parameter int unsigned ID_WIDTH = ID_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ID_WIDTH-1:0]         head_issue_id,
   input  logic [NUM_SIC-1:0]          req,
   input  logic [NUM_SIC*ID_WIDTH-1:0] req_issue_id,
   input  logic [NUM_SIC-1:0]          release_lock,
   input  logic [NUM_SIC*ADDR_W-1:0]   sic_addr,
   input  logic [NUM_SIC*DATA_W-1:0]   sic_wdata,
   input  logic [NUM_SIC-1:0]          sic_wen,
   output logic [NUM_SIC-1:0]          mem_grant,
   output logic [DATA_W-1:0]           mem_rdata,
   output logic [ADDR_W-1:0]           dmem_addr,
   output logic [DATA_W-1:0]           dmem_wdata,
   output logic                        dmem_wen,
   input  logic [DATA_W-1:0]           dmem_rdata
`ifdef SIC_MEM_ARB_STATS_EN
   ,
   output logic [31:0]                 stat_grants,
   output logic [31:0]                 stat_conflicts
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_SIC);

   logic [IDX_W-1:0]            gnt_idx_q, gnt_idx_d;
   logic                        gnt_vld_q, gnt_vld_d;
   logic [NUM_SIC-1:0]          mem_grant_q, mem_grant_d;
   logic [NUM_SIC-1:0]          elig;
   logic [NUM_SIC*ID_WIDTH-1:0] age_vec;
   logic                        sel_vld;
   logic [IDX_W-1:0]            sel_idx;
   logic                        wen_sel;

   // Per-SIC age relative to the issue head.
   always_comb begin
      age_vec = '0;
      for (int unsigned i = 0; i < NUM_SIC; i++) begin
         age_vec[i*ID_WIDTH +: ID_WIDTH] =
            ID_WIDTH'(age_of(ID_W_MAX'(req_issue_id[i*ID_WIDTH +: ID_WIDTH]),
                             ID_W_MAX'(head_issue_id), ID_WIDTH));
      end
   end

   // The SIC in its grant cycle still shows req; mask it so it is not regranted.
   assign elig = req & ~mem_grant_q;

   sic_mem_age_select #(
      .NUM_SIC  (NUM_SIC),
      .ID_WIDTH (ID_WIDTH)
   ) u_age_select (
      .elig_i  (elig),
      .age_i   (age_vec),
      .vld_c_o (sel_vld),
      .idx_c_o (sel_idx)
   );

   // Next grant decision.
   always_comb begin
      gnt_vld_d   = sel_vld;
      gnt_idx_d   = sel_idx;
      mem_grant_d = '0;
      if (sel_vld) begin
         mem_grant_d = NUM_SIC'(1) << sel_idx;
      end
   end

   // Grant registers; a grant lives for exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_idx_q   <= '0;
         gnt_vld_q   <= 1'b0;
         mem_grant_q <= '0;
      end else begin
         gnt_idx_q   <= gnt_idx_d;
         gnt_vld_q   <= gnt_vld_d;
         mem_grant_q <= mem_grant_d;
      end
   end

   // Memory-side mux driven by the registered grant index.
   always_comb begin
      dmem_addr  = '0;
      dmem_wdata = '0;
      wen_sel    = 1'b0;
      for (int unsigned i = 0; i < NUM_SIC; i++) begin
         if (gnt_idx_q == IDX_W'(i)) begin
            dmem_addr  = sic_addr[i*ADDR_W +: ADDR_W];
            dmem_wdata = sic_wdata[i*DATA_W +: DATA_W];
            wen_sel    = sic_wen[i];
         end
      end
      dmem_wen = gnt_vld_q & wen_sel;
   end

   assign mem_grant = mem_grant_q;
   assign mem_rdata = dmem_rdata;

`ifdef SIC_MEM_ARB_STATS_EN
   logic [31:0] stat_grants_q, stat_conflicts_q;
   logic        multi_elig;

   // Two or more bits set in the eligible vector.
   assign multi_elig = |(elig & (elig - NUM_SIC'(1)));

   // Saturating grant / conflict counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grants_q    <= '0;
         stat_conflicts_q <= '0;
      end else begin
         if (gnt_vld_q && (stat_grants_q != 32'hFFFF_FFFF)) begin
            stat_grants_q <= stat_grants_q + 32'd1;
         end
         if (multi_elig && (stat_conflicts_q != 32'hFFFF_FFFF)) begin
            stat_conflicts_q <= stat_conflicts_q + 32'd1;
         end
      end
   end

   assign stat_grants    = stat_grants_q;
   assign stat_conflicts = stat_conflicts_q;
`endif

`ifndef SYNTHESIS
   // Releasing a lock that is not currently granted is a SIC protocol error.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ((release_lock & ~mem_grant_q) == '0)
            else $error("sic_mem_arbiter: release_lock %b without grant %b",
                        release_lock, mem_grant_q);
      end
   end
`endif

endmodule

// File: tb/tb_sic_mem_arbiter.sv
module tb_sic_mem_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned IW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] head_issue_id;
   logic [N-1:0]  req;
   logic [N*IW-1:0] req_issue_id;
   logic [N-1:0]  release_lock;
   logic [N*30-1:0] sic_addr;
   logic [N*32-1:0] sic_wdata;
   logic [N-1:0]  sic_wen;
   logic [N-1:0]  mem_grant;
   logic [31:0]   mem_rdata;
   logic [29:0]   dmem_addr;
   logic [31:0]   dmem_wdata;
   logic          dmem_wen;
   logic [31:0]   dmem_rdata;
`ifdef SIC_MEM_ARB_STATS_EN
   logic [31:0]   stat_grants;
   logic [31:0]   stat_conflicts;
`endif

   int checks = 0;
   int errors = 0;

   sic_mem_arbiter #(.NUM_SIC(N), .ID_WIDTH(IW)) dut (
      .clk           (clk),
      .rst           (rst),
      .head_issue_id (head_issue_id),
      .req           (req),
      .req_issue_id  (req_issue_id),
      .release_lock  (release_lock),
      .sic_addr      (sic_addr),
      .sic_wdata     (sic_wdata),
      .sic_wen       (sic_wen),
      .mem_grant     (mem_grant),
      .mem_rdata     (mem_rdata),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_wen      (dmem_wen),
      .dmem_rdata    (dmem_rdata)
`ifdef SIC_MEM_ARB_STATS_EN
      ,
      .stat_grants   (stat_grants),
      .stat_conflicts(stat_conflicts)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sic(input int i, input logic r, input logic [IW-1:0] id,
                          input logic [29:0] a, input logic [31:0] d, input logic w);
      req[i]                = r;
      req_issue_id[i*IW +: IW] = id;
      sic_addr[i*30 +: 30]  = a;
      sic_wdata[i*32 +: 32] = d;
      sic_wen[i]            = w;
   endtask

   task automatic clear_all();
      req = '0; req_issue_id = '0; sic_addr = '0; sic_wdata = '0; sic_wen = '0;
      release_lock = '0; head_issue_id = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_all();
      dmem_rdata = 32'h0;
      req = 4'b1111; sic_wen = 4'b1111;
      step(); step();
      checks++; if (mem_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp %b", mem_grant, 4'b0000); end
      checks++; if (dmem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp %b", dmem_wen, 1'b0); end
`ifdef SIC_MEM_ARB_STATS_EN
      checks++; if (stat_grants !== 32'd0) begin errors++; $display("FAIL reset_stat_grants got %0d exp 0", stat_grants); end
      checks++; if (stat_conflicts !== 32'd0) begin errors++; $display("FAIL reset_stat_conflicts got %0d exp 0", stat_conflicts); end
`endif
      clear_all();
      rst = 1'b0;
      step();
      checks++; if (mem_grant !== 4'b0000) begin errors++; $display("FAIL idle_grant got %b exp %b", mem_grant, 4'b0000); end
   endtask

   task automatic test_single();
      head_issue_id = 6'd0;
      set_sic(2, 1'b1, 6'd5, 30'h10, 32'hDEAD_BEEF, 1'b1);
      dmem_rdata = 32'hCAFE_F00D;
      step();
      checks++; if (mem_grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp %b", mem_grant, 4'b0100); end
      checks++; if (dmem_wen !== 1'b1) begin errors++; $display("FAIL single_wen got %b exp %b", dmem_wen, 1'b1); end
      checks++; if (dmem_addr !== 30'h10) begin errors++; $display("FAIL single_addr got %h exp %h", dmem_addr, 30'h10); end
      checks++; if (dmem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata got %h exp %h", dmem_wdata, 32'hDEAD_BEEF); end
      checks++; if (mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL single_rdata got %h exp %h", mem_rdata, 32'hCAFE_F00D); end
      req[2] = 1'b0;
      step();
      checks++; if (mem_grant !== 4'b0000) begin errors++; $display("FAIL single_drain got %b exp %b", mem_grant, 4'b0000); end
      checks++; if (dmem_wen !== 1'b0) begin errors++; $display("FAIL single_drain_wen got %b exp %b", dmem_wen, 1'b0); end
      clear_all();
   endtask

   task automatic test_oldest();
      head_issue_id = 6'd10;
      set_sic(0, 1'b1, 6'd14, 30'h100, 32'h0000_0A0A, 1'b1);
      set_sic(3, 1'b1, 6'd11, 30'h300, 32'h0000_0303, 1'b0);
      step();
      checks++; if (mem_grant !== 4'b1000) begin errors++; $display("FAIL oldest_first got %b exp %b", mem_grant, 4'b1000); end
      checks++; if (dmem_addr !== 30'h300) begin errors++; $display("FAIL oldest_first_addr got %h exp %h", dmem_addr, 30'h300); end
      checks++; if (dmem_wen !== 1'b0) begin errors++; $display("FAIL oldest_first_wen got %b exp %b", dmem_wen, 1'b0); end
      req[3] = 1'b0;
      step();
      checks++; if (mem_grant !== 4'b0001) begin errors++; $display("FAIL oldest_second got %b exp %b", mem_grant, 4'b0001); end
      checks++; if (dmem_addr !== 30'h100) begin errors++; $display("FAIL oldest_second_addr got %h exp %h", dmem_addr, 30'h100); end
      checks++; if (dmem_wen !== 1'b1) begin errors++; $display("FAIL oldest_second_wen got %b exp %b", dmem_wen, 1'b1); end
      req[0] = 1'b0;
      step();
      checks++; if (mem_grant !== 4'b0000) begin errors++; $display("FAIL oldest_drain got %b exp %b", mem_grant, 4'b0000); end
      clear_all();
   endtask

   task automatic test_tie();
      head_issue_id = 6'd5;
      set_sic(1, 1'b1, 6'd9, 30'h11, 32'h1, 1'b0);
      set_sic(3, 1'b1, 6'd9, 30'h33, 32'h3, 1'b0);
      step();
      checks++; if (mem_grant !== 4'b0010) begin errors++; $display("FAIL tie_first got %b exp %b", mem_grant, 4'b0010); end
      req[1] = 1'b0;
      step();
      checks++; if (mem_grant !== 4'b1000) begin errors++; $display("FAIL tie_second got %b exp %b", mem_grant, 4'b1000); end
      req[3] = 1'b0;
      step();
      clear_all();
   endtask

   task automatic test_wrap();
      head_issue_id = 6'd62;
      set_sic(1, 1'b1, 6'd1, 30'h21, 32'h0, 1'b0);
      set_sic(2, 1'b1, 6'd63, 30'h22, 32'h0, 1'b0);
      step();
      checks++; if (mem_grant !== 4'b0100) begin errors++; $display("FAIL wrap_first got %b exp %b", mem_grant, 4'b0100); end
      req[2] = 1'b0;
      step();
      checks++; if (mem_grant !== 4'b0010) begin errors++; $display("FAIL wrap_second got %b exp %b", mem_grant, 4'b0010); end
      checks++; if (dmem_addr !== 30'h21) begin errors++; $display("FAIL wrap_second_addr got %h exp %h", dmem_addr, 30'h21); end
      req[1] = 1'b0;
      step();
      clear_all();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] exp_g [4];
      exp_g[0] = 4'b0100; exp_g[1] = 4'b0000; exp_g[2] = 4'b0100; exp_g[3] = 4'b0000;
      set_sic(2, 1'b1, 6'd3, 30'h44, 32'h4, 1'b0);
      for (int c = 0; c < 4; c++) begin
         step();
         checks++; if (mem_grant !== exp_g[c]) begin errors++; $display("FAIL b2b_cycle%0d got %b exp %b", c, mem_grant, exp_g[c]); end
      end
      req[2] = 1'b0;
      step(); step();
      clear_all();
   endtask

   task automatic test_abort();
      set_sic(1, 1'b1, 6'd3, 30'h55, 32'h5, 1'b1);
      step();
      req[1] = 1'b0; sic_wen[1] = 1'b0;
      #1;
      checks++; if (mem_grant !== 4'b0010) begin errors++; $display("FAIL abort_grant got %b exp %b", mem_grant, 4'b0010); end
      checks++; if (dmem_wen !== 1'b0) begin errors++; $display("FAIL abort_wen got %b exp %b", dmem_wen, 1'b0); end
      step();
      checks++; if (mem_grant !== 4'b0000) begin errors++; $display("FAIL abort_no_regrant1 got %b exp %b", mem_grant, 4'b0000); end
      step();
      checks++; if (mem_grant !== 4'b0000) begin errors++; $display("FAIL abort_no_regrant2 got %b exp %b", mem_grant, 4'b0000); end
      clear_all();
   endtask

   task automatic test_reset_mid_grant();
      set_sic(0, 1'b1, 6'd2, 30'h60, 32'h6, 1'b1);
      set_sic(1, 1'b1, 6'd4, 30'h61, 32'h7, 1'b1);
      step();
      checks++; if (mem_grant !== 4'b0001) begin errors++; $display("FAIL rstmid_pre got %b exp %b", mem_grant, 4'b0001); end
      rst = 1'b1;
      step();
      checks++; if (mem_grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant got %b exp %b", mem_grant, 4'b0000); end
      checks++; if (dmem_wen !== 1'b0) begin errors++; $display("FAIL rstmid_wen got %b exp %b", dmem_wen, 1'b0); end
      rst = 1'b0;
      step();
      checks++; if (mem_grant !== 4'b0001) begin errors++; $display("FAIL rstmid_regrant0 got %b exp %b", mem_grant, 4'b0001); end
      req[0] = 1'b0;
      step();
      checks++; if (mem_grant !== 4'b0010) begin errors++; $display("FAIL rstmid_regrant1 got %b exp %b", mem_grant, 4'b0010); end
      req[1] = 1'b0;
      step();
      clear_all();
   endtask

`ifdef SIC_MEM_ARB_STATS_EN
   task automatic test_stats();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_sic(0, 1'b1, 6'd1, 30'h70, 32'h0, 1'b0);
      set_sic(1, 1'b1, 6'd2, 30'h71, 32'h0, 1'b0);
      set_sic(2, 1'b1, 6'd3, 30'h72, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         req[k] = 1'b0;
      end
      step(); step();
      checks++; if (stat_grants !== 32'd3) begin errors++; $display("FAIL stats_grants got %0d exp 3", stat_grants); end
      checks++; if (stat_conflicts !== 32'd2) begin errors++; $display("FAIL stats_conflicts got %0d exp 2", stat_conflicts); end
      clear_all();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_oldest();
      test_tie();
      test_wrap();
      test_back_to_back();
      test_abort();
      test_reset_mid_grant();
`ifdef SIC_MEM_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
